// File: rtl/spart_pkg.sv
// Shared constants, FSM encoding and the baud-divisor lookup for the SPART bus master.
package spart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Divisors for a 50 MHz clock
  localparam logic [15:0] DIV_2400  = 16'h0A2C;
  localparam logic [15:0] DIV_4800  = 16'h0516;
  localparam logic [15:0] DIV_9600  = 16'h028B;
  localparam logic [15:0] DIV_19200 = 16'h0145;

  typedef enum logic [1:0] {
    CFG_LO,
    CFG_HI,
    RUN
  } drv_state_t;

  function automatic logic [15:0] br_to_div(input logic [1:0] br);
    logic [15:0] div;
    case (br)
      2'b00:   div = DIV_2400;
      2'b01:   div = DIV_4800;
      2'b10:   div = DIV_9600;
      default: div = DIV_19200;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_bus_if.sv
// Control/handshake side of the SPART bus; the bidirectional databus stays a plain inout net.
interface spart_bus_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver_echo_fifo.sv
// Synchronous byte FIFO holding received bytes until the transmitter can take them.
module echo_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor, then echoes every received byte back out
// through a small queue, reprogramming whenever the baud switches settle on a new value.
module spart_driver
  import spart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        br_cfg,
  spart_bus_if.master       bus,
  inout  wire  [DATA_W-1:0] databus,
  output logic [DATA_W-1:0] last_rx,
  output logic [PTR_W:0]    fifo_cnt,
  output logic              ovf
);

  drv_state_t        state;
  logic [1:0]        cfg_q;
  logic [1:0]        br_q;
  logic              wr_prev;
  logic [15:0]       div_w;
  logic              cfg_bus;
  logic              rd_now;
  logic              wr_now;
  logic              drive;
  logic              baud_chg;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] dout_c;
  logic [1:0]        ioaddr_c;

  assign div_w    = br_to_div(cfg_q);
  // rst gates the config cycle so the bus is idle while reset is held
  assign cfg_bus  = rst && (state != RUN);
  assign rd_now   = (state == RUN) && bus.rda;
  assign wr_now   = (state == RUN) && bus.tbr && !empty && !bus.rda && !wr_prev;
  assign drive    = cfg_bus || wr_now;
  assign baud_chg = (br_cfg != cfg_q) && (br_cfg == br_q);

  assign bus.iocs   = drive;
  assign bus.iorw   = !drive;
  assign bus.ioaddr = ioaddr_c;
  assign databus    = drive ? dout_c : 'z;

  always_comb begin
    ioaddr_c = ADDR_BUF;
    dout_c   = head;
    if (cfg_bus) begin
      if (state == CFG_LO) begin
        ioaddr_c = ADDR_DBL;
        dout_c   = div_w[7:0];
      end else begin
        ioaddr_c = ADDR_DBH;
        dout_c   = div_w[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CFG_LO;
      wr_prev <= 1'b0;
      last_rx <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        CFG_LO:  state <= CFG_HI;
        CFG_HI:  state <= RUN;
        RUN:     if (baud_chg) state <= CFG_LO;
        default: state <= CFG_LO;
      endcase
      wr_prev <= wr_now;
      if (rd_now) last_rx <= databus;
      if (rd_now && full) ovf <= 1'b1;
    end
  end

  // cfg_q tracks br_cfg while sitting in CFG_LO (including throughout reset)
  always_ff @(posedge clk) begin
    br_q <= br_cfg;
    if ((state == RUN) ? baud_chg : (state == CFG_LO)) cfg_q <= br_cfg;
  end

  echo_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_now),
    .pop   (wr_now),
    .din   (databus),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: directed scenarios plus random traffic, checked by a queue-based model.
module tb_spart_driver;

  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    br_cfg = 2'b10;
  wire  [7:0]    databus;
  logic          tb_drv = 1'b0;
  logic [7:0]    tb_byte = 8'h00;
  logic [7:0]    last_rx;
  logic [PW:0]   fifo_cnt;
  logic          ovf;

  spart_bus_if bus ();

  assign databus = tb_drv ? tb_byte : 8'hzz;

  spart_driver #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .bus      (bus.master),
    .databus  (databus),
    .last_rx  (last_rx),
    .fifo_cnt (fifo_cnt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Divisor straight from the baud rate: 50 MHz / (8 * baud), truncated
  function automatic logic [15:0] tb_div(input logic [1:0] br);
    int baud;
    baud = 2400 << br;
    return 16'(50_000_000 / (8 * baud));
  endfunction

  // Reference model state
  logic [7:0] mq[$];
  logic [9:0] ec[$];
  logic [7:0] wr_log[$];
  logic [7:0] cfg_log[$];
  logic [1:0] cfg_m;
  logic [1:0] br_prev;
  logic       prev_wr;
  logic       ovf_m;
  logic [7:0] last_m;
  logic       act_wr;
  logic       wr_exp;
  logic [9:0] e;
  logic [7:0] hd;
  logic [15:0] dv;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_iocs", 16'(bus.iocs), 16'd0);
      chk("rst_iorw", 16'(bus.iorw), 16'd1);
      chk("rst_cnt", 16'(fifo_cnt), 16'd0);
      chk("rst_ovf", 16'(ovf), 16'd0);
      chk("rst_last", 16'(last_rx), 16'd0);
      mq.delete();
      ec.delete();
      dv = tb_div(br_cfg);
      ec.push_back({2'b10, dv[7:0]});
      ec.push_back({2'b11, dv[15:8]});
      cfg_m   = br_cfg;
      prev_wr = 1'b0;
      ovf_m   = 1'b0;
      last_m  = 8'h00;
    end else begin
      chk("cnt", 16'(fifo_cnt), 16'(mq.size()));
      chk("last_rx", 16'(last_rx), 16'(last_m));
      chk("ovf", 16'(ovf), 16'(ovf_m));
      act_wr = bus.iocs && !bus.iorw;
      if (ec.size() > 0) begin
        e = ec.pop_front();
        chk("cfg_cs", 16'(act_wr), 16'd1);
        chk("cfg_addr", 16'(bus.ioaddr), 16'(e[9:8]));
        chk("cfg_data", 16'(databus), 16'(e[7:0]));
        cfg_log.push_back(databus);
        prev_wr = 1'b0;
      end else begin
        wr_exp = bus.tbr && !bus.rda && (mq.size() > 0) && !prev_wr;
        chk("wr_issue", 16'(act_wr), 16'(wr_exp));
        if (act_wr && mq.size() > 0) begin
          hd = mq.pop_front();
          chk("wr_addr", 16'(bus.ioaddr), 16'd0);
          chk("wr_data", 16'(databus), 16'(hd));
          wr_log.push_back(databus);
        end
        if (bus.rda) begin
          chk("rd_bus", 16'({bus.iocs, bus.iorw}), 16'b01);
          chk("rd_contend", 16'(databus), 16'(tb_byte));
          last_m = tb_byte;
          if (mq.size() < DEPTH) mq.push_back(tb_byte);
          else ovf_m = 1'b1;
        end
        if (br_cfg != cfg_m && br_cfg == br_prev) begin
          cfg_m = br_cfg;
          dv = tb_div(br_cfg);
          ec.push_back({2'b10, dv[7:0]});
          ec.push_back({2'b11, dv[15:8]});
        end
        prev_wr = act_wr;
      end
    end
    br_prev = br_cfg;
  end

  task automatic drive(input logic r, input logic [7:0] b, input logic t);
    bus.rda = r;
    tb_drv  = r;
    tb_byte = b;
    bus.tbr = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_rda();
    bus.rda = 1'b0;
    tb_drv  = 1'b0;
  endtask

  initial begin
    bus.rda = 1'b0;
    bus.tbr = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset release with 9600 baud selected
    rst = 1'b1;
    #1;
    chk("c1_iocs", 16'(bus.iocs), 16'd1);
    chk("c1_iorw", 16'(bus.iorw), 16'd0);
    chk("c1_addr", 16'(bus.ioaddr), 16'd2);
    chk("c1_data", 16'(databus), 16'h8B);
    @(posedge clk); #1;
    chk("c2_addr", 16'(bus.ioaddr), 16'd3);
    chk("c2_data", 16'(databus), 16'h02);
    @(posedge clk); #1;
    chk("c3_bus", 16'({bus.iocs, bus.iorw, bus.ioaddr}), 16'b0100);

    // Single echo with minimum latency
    drive(1'b1, 8'h41, 1'b1);
    idle_rda();
    #1;
    chk("echo_last", 16'(last_rx), 16'h41);
    chk("echo_bus", 16'({bus.iocs, bus.iorw, bus.ioaddr}), 16'b1000);
    chk("echo_data", 16'(databus), 16'h41);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("echo_cnt", 16'(fifo_cnt), 16'd0);

    // Overflow: five bytes into a four-entry queue
    wr_log.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_cnt", 16'(fifo_cnt), 16'd4);
    chk("ovf_flag", 16'(ovf), 16'd1);
    chk("ovf_last", 16'(last_rx), 16'h14);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
    end
    chk("ovf_nwr", 16'(wr_log.size()), 16'd4);
    for (int i = 0; i < 4; i++)
      if (i < wr_log.size()) chk("ovf_order", 16'(wr_log[i]), 16'(8'h10 + 8'(i)));

    // Read wins over an eligible write
    wr_log.delete();
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'hBB, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("prio_nwr", 16'(wr_log.size()), 16'd2);
    if (wr_log.size() == 2) begin
      chk("prio_w0", 16'(wr_log[0]), 16'hAA);
      chk("prio_w1", 16'(wr_log[1]), 16'hBB);
    end

    // Baud change 9600 -> 2400 with two bytes queued
    wr_log.delete();
    cfg_log.delete();
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h66, 1'b0);
    br_cfg = 2'b00;
    repeat (5) drive(1'b0, 8'h00, 1'b0);
    chk("baud_cnt", 16'(fifo_cnt), 16'd2);
    chk("baud_ncfg", 16'(cfg_log.size()), 16'd2);
    if (cfg_log.size() == 2) begin
      chk("baud_lo", 16'(cfg_log[0]), 16'h2C);
      chk("baud_hi", 16'(cfg_log[1]), 16'h0A);
    end
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("baud_nwr", 16'(wr_log.size()), 16'd2);
    if (wr_log.size() == 2) begin
      chk("baud_w0", 16'(wr_log[0]), 16'h55);
      chk("baud_w1", 16'(wr_log[1]), 16'h66);
    end

    // Reset asserted in the middle of a write cycle
    drive(1'b1, 8'h77, 1'b0);
    idle_rda();
    bus.tbr = 1'b1;
    #1;
    chk("mid_wr", 16'({bus.iocs, bus.iorw}), 16'b10);
    chk("mid_data", 16'(databus), 16'h77);
    rst = 1'b0;
    #1;
    chk("mid_rst_bus", 16'({bus.iocs, bus.iorw}), 16'b01);
    chk("mid_rst_cnt", 16'(fifo_cnt), 16'd0);
    chk("mid_rst_ovf", 16'(ovf), 16'd0);
    tb_byte = 8'h5A;
    tb_drv  = 1'b1;
    #1;
    chk("mid_rst_rel", 16'(databus), 16'h5A);
    tb_drv  = 1'b0;
    bus.tbr = 1'b0;
    cfg_log.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    chk("rcfg_n", 16'(cfg_log.size()), 16'd2);
    if (cfg_log.size() == 2) begin
      chk("rcfg_lo", 16'(cfg_log[0]), 16'h2C);
      chk("rcfg_hi", 16'(cfg_log[1]), 16'h0A);
    end

    // Random traffic with occasional baud changes and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        br_cfg = 2'($urandom);
        repeat (5) drive(1'b0, 8'h00, 1'($urandom));
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (3) drive(1'b0, 8'h00, 1'b0);
      end else begin
        drive(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 2) != 0));
      end
    end
    repeat (3) drive(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
